// File: rtl/nes_attr_palette_sel_pkg.sv
// Shared constants, tag layout and quadrant helper for the NES attribute
// palette-select pipeline.
package nes_attr_palette_sel_pkg;

  localparam int NES_W    = 256;  // NES picture width in NES pixels
  localparam int NES_H    = 240;  // NES picture height in NES pixels
  localparam int ATTR_AW  = 7;    // attribute ROM address width {nt, arow, acol}
  localparam int ATTR_BLK = 32;   // pixels covered by one attribute byte per axis
  localparam int QUAD     = 16;   // pixels covered by one 2-bit palette field per axis

  localparam int BLK_LSB  = $clog2(ATTR_BLK);
  localparam int QUAD_LSB = $clog2(QUAD);

  // Quadrant encoding {qy, qx} inside a 32x32 attribute block.
  localparam logic [1:0] QUAD_TL = 2'b00;
  localparam logic [1:0] QUAD_TR = 2'b01;
  localparam logic [1:0] QUAD_BL = 2'b10;
  localparam logic [1:0] QUAD_BR = 2'b11;

  // Per-pixel side information that travels alongside the ROM read.
  typedef struct packed {
    logic in_pic;
    logic qy;
    logic qx;
  } attr_tag_t;

  // Pick the 2-bit palette field of an attribute byte for a quadrant.
  function automatic logic [1:0] quad_pick(input logic [7:0] attr, input logic [1:0] sh);
    logic [1:0] sel;
    sel = attr[1:0];
    case (sh)
      QUAD_TL: sel = attr[1:0];
      QUAD_TR: sel = attr[3:2];
      QUAD_BL: sel = attr[5:4];
      QUAD_BR: sel = attr[7:6];
      default: sel = attr[1:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/nes_attr_palette_sel_attr_tag_pipe.sv
// Two-stage delay for the per-pixel tag so it lines up with the ROM data.
// A synchronous clear drops any in-flight pixels on reset.
module attr_tag_pipe
  import nes_attr_palette_sel_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  attr_tag_t i_tag,
  output attr_tag_t o_tag
);

  attr_tag_t r_tag_s1;
  attr_tag_t r_tag_s2;

  // Shift the tag two stages; reset flushes both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_s1 <= '0;
      r_tag_s2 <= '0;
    end else begin
      r_tag_s1 <= i_tag;
      r_tag_s2 <= r_tag_s1;
    end
  end

  assign o_tag = r_tag_s2;

endmodule

// File: rtl/nes_attr_palette_sel.sv
// Maps VGA pixel counters plus a horizontal scroll to an attribute ROM
// address, then picks the 2-bit palette select for the pixel's quadrant.
// Output lags col/row by exactly three clocks, one pixel per clock.
module nes_attr_palette_sel
  import nes_attr_palette_sel_pkg::*;
#(
  parameter int PIX_SHIFT = 1,
  parameter int X_OFS     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         col,
  input  logic [9:0]         row,
  input  logic               visible,
  input  logic               frame_start,
  input  logic [8:0]         scroll_x,
  output logic [ATTR_AW-1:0] attr_addr,
  input  logic [7:0]         attr_dout,
  output logic [1:0]         pal_sel,
  output logic               pal_valid
);

  logic [8:0]         r_scroll_q;
  logic [10:0]        w_sx;
  logic [9:0]         w_sy;
  logic               w_in_pic;
  logic [8:0]         w_wx;
  logic [ATTR_AW-1:0] w_addr;
  attr_tag_t          w_tag_s0;
  attr_tag_t          w_tag_s2;

  // Scroll is only picked up at frame start so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scroll_q <= '0;
    end else if (frame_start) begin
      r_scroll_q <= scroll_x;
    end
  end

  // Pixel coordinate mapping and attribute address formation.
  always_comb begin
    // Columns left of the picture go negative and wrap to large unsigned
    // values, so one unsigned compare against NES_W rejects both sides.
    w_sx     = 11'({1'b0, col} >> PIX_SHIFT) - 11'(X_OFS);
    w_sy     = row >> PIX_SHIFT;
    w_in_pic = visible && (w_sx < 11'(NES_W)) && (w_sy < 10'(NES_H));
    w_wx     = {1'b0, w_sx[7:0]} + r_scroll_q;
    w_addr   = {w_wx[8], w_sy[BLK_LSB+2:BLK_LSB], w_wx[BLK_LSB+2:BLK_LSB]};
    w_tag_s0 = '{in_pic: w_in_pic, qy: w_sy[QUAD_LSB], qx: w_wx[QUAD_LSB]};
  end

  // Address register; held outside the picture to avoid needless ROM toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      attr_addr <= '0;
    end else if (w_in_pic) begin
      attr_addr <= w_addr;
    end
  end

  attr_tag_pipe u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_s0),
    .o_tag (w_tag_s2)
  );

  // Final stage: select the quadrant field, forced to zero outside the picture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pal_sel   <= 2'b00;
      pal_valid <= 1'b0;
    end else begin
      pal_valid <= w_tag_s2.in_pic;
      pal_sel   <= w_tag_s2.in_pic ? quad_pick(attr_dout, {w_tag_s2.qy, w_tag_s2.qx}) : 2'b00;
    end
  end

endmodule
